// File: rtl/mxu_seq_ctrl.sv
// MXU sequencer: accepts one command, streams operand rows into the MXU, waits for results,
// then drains result rows. Optional WAIT watchdog is built in with `define MXU_SEQ_TMO_EN.
module mxu_seq_ctrl #(
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_vld,
  output logic         cmd_rdy,
  input  logic         cmd_clr,
  input  logic [3:0]   cmd_len,
  input  logic         cmd_act_vld,
  input  logic [1:0]   cmd_act_type,
  input  logic         cmd_pool_vld,
  input  logic [1:0]   cmd_pool_size,
  input  logic         row_vld,
  output logic         row_rdy,
  input  logic [127:0] row_iram_pld,
  input  logic [127:0] row_wram_pld,
  output logic         lsu_mxu_vld,
  output logic         lsu_mxu_clr,
  output logic         lsu_mxu_wfi,
  output logic [15:0]  lsu_mxu_iram_vld,
  output logic [15:0]  lsu_mxu_wram_vld,
  output logic [127:0] lsu_mxu_iram_pld,
  output logic [127:0] lsu_mxu_wram_pld,
  output logic         lsu_mxu_act_vld,
  output logic [1:0]   lsu_mxu_act_type,
  output logic         lsu_mxu_pool_vld,
  output logic [1:0]   lsu_mxu_pool_size,
  input  logic         mxu_lsu_rdy,
  input  logic         mxu_lsu_data_rdy,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [3:0]   res_idx,
  output logic         err_tmo
);

  typedef enum logic [2:0] {StIdle, StClr, StLoad, StWait, StDrain} state_e;

  state_e     state_q;
  logic [3:0] len_q;
  logic [3:0] row_cnt_q;

`ifdef MXU_SEQ_TMO_EN
  localparam int unsigned TmoW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  logic [TmoW-1:0] tmo_cnt_q;
`else
  // TMO_CYC only matters when the watchdog is built in.
  assign err_tmo = 1'b0 & (TMO_CYC == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      len_q             <= '0;
      row_cnt_q         <= '0;
      cmd_rdy           <= 1'b0;
      row_rdy           <= 1'b0;
      lsu_mxu_vld       <= 1'b0;
      lsu_mxu_clr       <= 1'b0;
      lsu_mxu_wfi       <= 1'b0;
      lsu_mxu_iram_vld  <= '0;
      lsu_mxu_wram_vld  <= '0;
      lsu_mxu_iram_pld  <= '0;
      lsu_mxu_wram_pld  <= '0;
      lsu_mxu_act_vld   <= 1'b0;
      lsu_mxu_act_type  <= '0;
      lsu_mxu_pool_vld  <= 1'b0;
      lsu_mxu_pool_size <= '0;
      res_vld           <= 1'b0;
      res_idx           <= '0;
`ifdef MXU_SEQ_TMO_EN
      tmo_cnt_q         <= '0;
      err_tmo           <= 1'b0;
`endif
    end else begin
      // Strobes default low; only the cycle that raises them holds them high.
      lsu_mxu_vld      <= 1'b0;
      lsu_mxu_clr      <= 1'b0;
      lsu_mxu_iram_vld <= '0;
      lsu_mxu_wram_vld <= '0;
`ifdef MXU_SEQ_TMO_EN
      err_tmo          <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (cmd_vld && cmd_rdy) begin
            cmd_rdy           <= 1'b0;
            len_q             <= cmd_len;
            row_cnt_q         <= '0;
            lsu_mxu_act_vld   <= cmd_act_vld;
            lsu_mxu_act_type  <= cmd_act_type;
            lsu_mxu_pool_vld  <= cmd_pool_vld;
            lsu_mxu_pool_size <= cmd_pool_size;
            if (cmd_clr) begin
              state_q     <= StClr;
              lsu_mxu_clr <= 1'b1;
            end else begin
              state_q <= StLoad;
              row_rdy <= 1'b1;
            end
          end else begin
            cmd_rdy <= mxu_lsu_rdy;
          end
        end
        StClr: begin
          state_q <= StLoad;
          row_rdy <= 1'b1;
        end
        StLoad: begin
          if (row_vld && row_rdy) begin
            lsu_mxu_vld      <= 1'b1;
            lsu_mxu_iram_vld <= 16'h0001 << row_cnt_q;
            lsu_mxu_wram_vld <= 16'h0001 << row_cnt_q;
            lsu_mxu_iram_pld <= row_iram_pld;
            lsu_mxu_wram_pld <= row_wram_pld;
            if (row_cnt_q == len_q) begin
              state_q     <= StWait;
              row_rdy     <= 1'b0;
              lsu_mxu_wfi <= 1'b1;
              row_cnt_q   <= '0;
`ifdef MXU_SEQ_TMO_EN
              tmo_cnt_q   <= '0;
`endif
            end else begin
              row_cnt_q <= row_cnt_q + 4'd1;
            end
          end
        end
        StWait: begin
          if (mxu_lsu_data_rdy) begin
            state_q     <= StDrain;
            lsu_mxu_wfi <= 1'b0;
            res_vld     <= 1'b1;
            res_idx     <= '0;
          end
`ifdef MXU_SEQ_TMO_EN
          else if (tmo_cnt_q == TmoW'(TMO_CYC - 1)) begin
            state_q     <= StIdle;
            lsu_mxu_wfi <= 1'b0;
            lsu_mxu_clr <= 1'b1;
            err_tmo     <= 1'b1;
            cmd_rdy     <= mxu_lsu_rdy;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StDrain: begin
          if (res_rdy) begin
            if (res_idx == len_q) begin
              state_q <= StIdle;
              res_vld <= 1'b0;
              res_idx <= '0;
              cmd_rdy <= mxu_lsu_rdy;
            end else begin
              res_idx <= res_idx + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mxu_seq_ctrl.sv
// Directed, table-driven bench for mxu_seq_ctrl; the watchdog section follows MXU_SEQ_TMO_EN.
module tb_mxu_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_vld, cmd_rdy, cmd_clr;
  logic [3:0]   cmd_len;
  logic         cmd_act_vld, cmd_pool_vld;
  logic [1:0]   cmd_act_type, cmd_pool_size;
  logic         row_vld, row_rdy;
  logic [127:0] row_iram_pld, row_wram_pld;
  logic         lsu_mxu_vld, lsu_mxu_clr, lsu_mxu_wfi;
  logic [15:0]  lsu_mxu_iram_vld, lsu_mxu_wram_vld;
  logic [127:0] lsu_mxu_iram_pld, lsu_mxu_wram_pld;
  logic         lsu_mxu_act_vld, lsu_mxu_pool_vld;
  logic [1:0]   lsu_mxu_act_type, lsu_mxu_pool_size;
  logic         mxu_lsu_rdy, mxu_lsu_data_rdy;
  logic         res_vld, res_rdy;
  logic [3:0]   res_idx;
  logic         err_tmo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mxu_seq_ctrl #(.TMO_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_clr(cmd_clr), .cmd_len(cmd_len),
    .cmd_act_vld(cmd_act_vld), .cmd_act_type(cmd_act_type),
    .cmd_pool_vld(cmd_pool_vld), .cmd_pool_size(cmd_pool_size),
    .row_vld(row_vld), .row_rdy(row_rdy),
    .row_iram_pld(row_iram_pld), .row_wram_pld(row_wram_pld),
    .lsu_mxu_vld(lsu_mxu_vld), .lsu_mxu_clr(lsu_mxu_clr), .lsu_mxu_wfi(lsu_mxu_wfi),
    .lsu_mxu_iram_vld(lsu_mxu_iram_vld), .lsu_mxu_wram_vld(lsu_mxu_wram_vld),
    .lsu_mxu_iram_pld(lsu_mxu_iram_pld), .lsu_mxu_wram_pld(lsu_mxu_wram_pld),
    .lsu_mxu_act_vld(lsu_mxu_act_vld), .lsu_mxu_act_type(lsu_mxu_act_type),
    .lsu_mxu_pool_vld(lsu_mxu_pool_vld), .lsu_mxu_pool_size(lsu_mxu_pool_size),
    .mxu_lsu_rdy(mxu_lsu_rdy), .mxu_lsu_data_rdy(mxu_lsu_data_rdy),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_idx(res_idx), .err_tmo(err_tmo)
  );

  // in_bits : cmd_vld cmd_clr row_vld data_rdy res_rdy mxu_lsu_rdy
  // exp_bits: cmd_rdy row_rdy clr vld wfi res_vld   (expected after the next rising edge)
  typedef struct packed {
    logic [5:0]  in_bits;
    logic [3:0]  len;
    logic [7:0]  seed;
    logic [5:0]  opt;
    logic [5:0]  exp_bits;
    logic [15:0] exp_iv;
    logic [3:0]  exp_idx;
    logic [7:0]  exp_seed;
    logic [5:0]  exp_opt;
  } vec_t;

  localparam int NumVec = 23;
  vec_t vecs [NumVec];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] in_bits, input logic [3:0] len, input logic [7:0] seed,
                       input logic [5:0] opt);
    {cmd_vld, cmd_clr, row_vld, mxu_lsu_data_rdy, res_rdy, mxu_lsu_rdy} = in_bits;
    cmd_len = len;
    row_iram_pld = {16{seed}};
    row_wram_pld = {16{~seed}};
    {cmd_act_vld, cmd_act_type, cmd_pool_vld, cmd_pool_size} = opt;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] eb, input logic [15:0] eiv,
                            input logic [3:0] eidx, input logic eerr, input logic [7:0] eseed);
    chk({tag, ".cmd_rdy"}, 128'(cmd_rdy), 128'(eb[5]));
    chk({tag, ".row_rdy"}, 128'(row_rdy), 128'(eb[4]));
    chk({tag, ".clr"}, 128'(lsu_mxu_clr), 128'(eb[3]));
    chk({tag, ".vld"}, 128'(lsu_mxu_vld), 128'(eb[2]));
    chk({tag, ".wfi"}, 128'(lsu_mxu_wfi), 128'(eb[1]));
    chk({tag, ".res_vld"}, 128'(res_vld), 128'(eb[0]));
    chk({tag, ".iram_vld"}, 128'(lsu_mxu_iram_vld), 128'(eiv));
    chk({tag, ".wram_vld"}, 128'(lsu_mxu_wram_vld), 128'(eiv));
    chk({tag, ".res_idx"}, 128'(res_idx), 128'(eidx));
    chk({tag, ".err_tmo"}, 128'(err_tmo), 128'(eerr));
    if (eb[2]) begin
      chk({tag, ".iram_pld"}, lsu_mxu_iram_pld, {16{eseed}});
      chk({tag, ".wram_pld"}, lsu_mxu_wram_pld, {16{~eseed}});
    end
  endtask

  function automatic logic [5:0] opt_out();
    return {lsu_mxu_act_vld, lsu_mxu_act_type, lsu_mxu_pool_vld, lsu_mxu_pool_size};
  endfunction

  initial begin
    // Command len=3 with clear, 4 back-to-back rows, WAIT, drain 4 results.
    vecs[0]  = '{6'b110001, 4'd3, 8'h00, 6'h37, 6'b001000, 16'h0000, 4'd0, 8'h00, 6'h37};
    vecs[1]  = '{6'b000001, 4'd0, 8'h00, 6'h37, 6'b010000, 16'h0000, 4'd0, 8'h00, 6'h37};
    vecs[2]  = '{6'b001001, 4'd0, 8'hA1, 6'h37, 6'b010100, 16'h0001, 4'd0, 8'hA1, 6'h37};
    vecs[3]  = '{6'b001001, 4'd0, 8'hA2, 6'h37, 6'b010100, 16'h0002, 4'd0, 8'hA2, 6'h37};
    vecs[4]  = '{6'b001001, 4'd0, 8'hA3, 6'h37, 6'b010100, 16'h0004, 4'd0, 8'hA3, 6'h37};
    vecs[5]  = '{6'b001001, 4'd0, 8'hA4, 6'h37, 6'b000110, 16'h0008, 4'd0, 8'hA4, 6'h37};
    vecs[6]  = '{6'b001001, 4'd0, 8'hA5, 6'h37, 6'b000010, 16'h0000, 4'd0, 8'h00, 6'h37};
    vecs[7]  = '{6'b000011, 4'd0, 8'h00, 6'h37, 6'b000010, 16'h0000, 4'd0, 8'h00, 6'h37};
    vecs[8]  = '{6'b000101, 4'd0, 8'h00, 6'h37, 6'b000001, 16'h0000, 4'd0, 8'h00, 6'h37};
    vecs[9]  = '{6'b000011, 4'd0, 8'h00, 6'h37, 6'b000001, 16'h0000, 4'd1, 8'h00, 6'h37};
    vecs[10] = '{6'b000011, 4'd0, 8'h00, 6'h37, 6'b000001, 16'h0000, 4'd2, 8'h00, 6'h37};
    vecs[11] = '{6'b000011, 4'd0, 8'h00, 6'h37, 6'b000001, 16'h0000, 4'd3, 8'h00, 6'h37};
    vecs[12] = '{6'b000011, 4'd0, 8'h00, 6'h37, 6'b100000, 16'h0000, 4'd0, 8'h00, 6'h37};
    // Command len=1, no clear; res_rdy held low 3 cycles; stray cmd/data_rdy ignored.
    vecs[13] = '{6'b100001, 4'd1, 8'h00, 6'h0A, 6'b010000, 16'h0000, 4'd0, 8'h00, 6'h0A};
    vecs[14] = '{6'b001101, 4'd0, 8'h11, 6'h0A, 6'b010100, 16'h0001, 4'd0, 8'h11, 6'h0A};
    vecs[15] = '{6'b001001, 4'd0, 8'h22, 6'h0A, 6'b000110, 16'h0002, 4'd0, 8'h22, 6'h0A};
    vecs[16] = '{6'b100101, 4'd0, 8'h00, 6'h3F, 6'b000001, 16'h0000, 4'd0, 8'h00, 6'h0A};
    vecs[17] = '{6'b000001, 4'd0, 8'h00, 6'h0A, 6'b000001, 16'h0000, 4'd0, 8'h00, 6'h0A};
    vecs[18] = '{6'b000001, 4'd0, 8'h00, 6'h0A, 6'b000001, 16'h0000, 4'd0, 8'h00, 6'h0A};
    vecs[19] = '{6'b000011, 4'd0, 8'h00, 6'h0A, 6'b000001, 16'h0000, 4'd1, 8'h00, 6'h0A};
    vecs[20] = '{6'b000011, 4'd0, 8'h00, 6'h0A, 6'b100000, 16'h0000, 4'd0, 8'h00, 6'h0A};
    vecs[21] = '{6'b000100, 4'd0, 8'h00, 6'h0A, 6'b000000, 16'h0000, 4'd0, 8'h00, 6'h0A};
    vecs[22] = '{6'b000001, 4'd0, 8'h00, 6'h0A, 6'b100000, 16'h0000, 4'd0, 8'h00, 6'h0A};

    // Reset: everything low, including cmd_rdy while rst is held.
    drive(6'b000001, 4'd0, 8'h00, 6'h00);
    rst = 1'b1;
    step();
    step();
    expect_out("rst", 6'b000000, 16'h0000, 4'd0, 1'b0, 8'h00);
    chk("rst.opt", 128'(opt_out()), 128'(6'h00));
    rst = 1'b0;
    step();
    expect_out("post_rst", 6'b100000, 16'h0000, 4'd0, 1'b0, 8'h00);

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].in_bits, vecs[i].len, vecs[i].seed, vecs[i].opt);
      step();
      expect_out($sformatf("v%0d", i), vecs[i].exp_bits, vecs[i].exp_iv, vecs[i].exp_idx, 1'b0,
                 vecs[i].exp_seed);
      chk($sformatf("v%0d.opt", i), 128'(opt_out()), 128'(vecs[i].exp_opt));
    end

    // len=15, row_vld every other cycle: 16 one-hot writes with bubbles in between.
    drive(6'b100001, 4'd15, 8'h00, 6'h15);
    step();
    expect_out("l15.cmd", 6'b010000, 16'h0000, 4'd0, 1'b0, 8'h00);
    for (int c = 0; c < 32; c++) begin
      drive({2'b00, (c % 2) == 0, 3'b001}, 4'd0, 8'(c), 6'h00);
      step();
      if ((c % 2) == 0) begin
        expect_out($sformatf("l15.c%0d", c), {1'b0, c != 30, 2'b01, c == 30, 1'b0},
                   16'h0001 << (c / 2), 4'd0, 1'b0, 8'(c));
      end else begin
        expect_out($sformatf("l15.c%0d", c), {1'b0, c != 31, 2'b00, c == 31, 1'b0},
                   16'h0000, 4'd0, 1'b0, 8'h00);
      end
    end
    chk("l15.opt", 128'(opt_out()), 128'(6'h15));
`ifndef MXU_SEQ_TMO_EN
    // Without the watchdog, WAIT holds indefinitely.
    for (int h = 0; h < 40; h++) begin
      drive(6'b000001, 4'd0, 8'h00, 6'h00);
      step();
      expect_out($sformatf("hold%0d", h), 6'b000010, 16'h0000, 4'd0, 1'b0, 8'h00);
    end
`endif
    drive(6'b000101, 4'd0, 8'h00, 6'h00);
    step();
    expect_out("l15.drain", 6'b000001, 16'h0000, 4'd0, 1'b0, 8'h00);
    for (int j = 0; j < 16; j++) begin
      drive(6'b000011, 4'd0, 8'h00, 6'h00);
      step();
      if (j < 15) begin
        expect_out($sformatf("l15.r%0d", j), 6'b000001, 16'h0000, 4'(j + 1), 1'b0, 8'h00);
      end else begin
        expect_out("l15.done", 6'b100000, 16'h0000, 4'd0, 1'b0, 8'h00);
      end
    end

    // Reset in LOAD after two rows: command aborted, no further strobes.
    drive(6'b110001, 4'd3, 8'h00, 6'h2D);
    step();
    expect_out("ab.cmd", 6'b001000, 16'h0000, 4'd0, 1'b0, 8'h00);
    drive(6'b000001, 4'd0, 8'h00, 6'h00);
    step();
    expect_out("ab.clr", 6'b010000, 16'h0000, 4'd0, 1'b0, 8'h00);
    drive(6'b001001, 4'd0, 8'h51, 6'h00);
    step();
    expect_out("ab.r0", 6'b010100, 16'h0001, 4'd0, 1'b0, 8'h51);
    drive(6'b001001, 4'd0, 8'h52, 6'h00);
    step();
    expect_out("ab.r1", 6'b010100, 16'h0002, 4'd0, 1'b0, 8'h52);
    rst = 1'b1;
    drive(6'b001001, 4'd0, 8'h53, 6'h00);
    step();
    expect_out("ab.rst", 6'b000000, 16'h0000, 4'd0, 1'b0, 8'h00);
    chk("ab.opt", 128'(opt_out()), 128'(6'h00));
    chk("ab.pld", lsu_mxu_iram_pld, 128'h0);
    rst = 1'b0;
    step();
    expect_out("ab.idle0", 6'b100000, 16'h0000, 4'd0, 1'b0, 8'h00);
    step();
    expect_out("ab.idle1", 6'b100000, 16'h0000, 4'd0, 1'b0, 8'h00);

`ifdef MXU_SEQ_TMO_EN
    // Watchdog: err_tmo and clr pulse 8 cycles after WAIT entry, then IDLE.
    drive(6'b100001, 4'd0, 8'h00, 6'h00);
    step();
    expect_out("tmo.cmd", 6'b010000, 16'h0000, 4'd0, 1'b0, 8'h00);
    drive(6'b001001, 4'd0, 8'h77, 6'h00);
    step();
    expect_out("tmo.row", 6'b000110, 16'h0001, 4'd0, 1'b0, 8'h77);
    for (int k = 1; k <= 9; k++) begin
      drive(6'b000001, 4'd0, 8'h00, 6'h00);
      step();
      if (k < 8) begin
        expect_out($sformatf("tmo.w%0d", k), 6'b000010, 16'h0000, 4'd0, 1'b0, 8'h00);
      end else if (k == 8) begin
        expect_out("tmo.fire", 6'b101000, 16'h0000, 4'd0, 1'b1, 8'h00);
      end else begin
        expect_out("tmo.after", 6'b100000, 16'h0000, 4'd0, 1'b0, 8'h00);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
